// File: rtl/booth_seq_mult.sv
// booth_seq_mult
//   Sequential radix-4 Booth multiplier, 8x8 unsigned -> 16-bit product.
//   Five Booth digits are retired one per cycle through a single
//   partial-product selector and an 18-bit accumulator.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   operand request, sampled only while in_ready=1
//   multiplicand in   [7:0] unsigned M
//   multiplier   in   [7:0] unsigned Y
//   in_ready     out  high only in IDLE
//   action       out  [2:0] Booth action of the digit being retired
//                     (000 zero, 100 +M, 010 +2M, 101 -M, 011 -2M)
//   product      out  [15:0] result register
//   out_valid    out  result available, held until accepted
//   out_ready    in   consumer accept
module booth_seq_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        in_ready,
  output logic [2:0]  action,
  output logic [15:0] product,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_m;
  logic [9:0]  r_y;
  logic [17:0] r_acc;
  logic [2:0]  r_cnt;
  logic [15:0] r_product;
  logic        r_out_valid;
  logic [2:0]  r_action;

  logic        w_last;
  logic [2:0]  w_cnt_inc;
  logic [10:0] w_yx;
  logic [2:0]  w_trip_next;
  logic [9:0]  w_mag;
  logic [9:0]  w_pp;
  logic [17:0] w_pp_shift;
  logic [17:0] w_acc_next;

  // Triplet {Y[2i+1], Y[2i], Y[2i-1]} -> action code.
  // Bit 0 of the code marks a negative partial product.
  function automatic logic [2:0] f_recode(input logic [2:0] trip);
    logic [2:0] act;
    case (trip)
      3'b001, 3'b010: act = 3'b100;
      3'b011:         act = 3'b010;
      3'b100:         act = 3'b011;
      3'b101, 3'b110: act = 3'b101;
      default:        act = 3'b000;
    endcase
    return act;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          w_state_next = CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (r_out_valid && out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- Datapath ----------------
  assign w_last    = (r_cnt == 3'd4);
  assign w_cnt_inc = r_cnt + 3'd1;

  // Y with the implicit Y[-1]=0 appended, so digit i sits at bits [2i+2:2i].
  assign w_yx        = {r_y, 1'b0};
  assign w_trip_next = 3'(w_yx >> {w_cnt_inc, 1'b0});

  // The registered action already encodes the selector for the digit being
  // retired, so the partial product is built from it directly.
  always_comb begin
    w_mag = '0;
    if (r_action[2]) begin
      w_mag = {2'b00, r_m};
    end else if (r_action[1]) begin
      w_mag = {1'b0, r_m, 1'b0};
    end
  end

  assign w_pp       = r_action[0] ? (~w_mag + 10'd1) : w_mag;
  assign w_pp_shift = {{8{w_pp[9]}}, w_pp} << {r_cnt, 1'b0};
  assign w_acc_next = r_acc + w_pp_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m         <= '0;
      r_y         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
      r_action    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_m      <= multiplicand;
            r_y      <= {2'b00, multiplier};
            r_acc    <= '0;
            r_cnt    <= '0;
            r_action <= f_recode({multiplier[1:0], 1'b0});
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= w_cnt_inc;
          if (w_last) begin
            r_product   <= w_acc_next[15:0];
            r_out_valid <= 1'b1;
            r_action    <= '0;
          end else begin
            r_action <= f_recode(w_trip_next);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign action    = r_action;
  assign product   = r_product;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Scoreboard bench for booth_seq_mult: the driver pushes operands and the
// acceptance cycle; the monitor pops on out_valid and checks product,
// latency, per-digit actions and handshake behaviour.
module tb_booth_seq_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [2:0]  action;
  logic [15:0] product;
  logic        out_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] m;
    logic [7:0] y;
    int         c0;
  } txn_t;

  txn_t q[$];
  logic [2:0] act_log[int];
  logic       ir_log[int];

  booth_seq_mult dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .in_ready     (in_ready),
    .action       (action),
    .product      (product),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    act_log[cyc] = action;
    ir_log[cyc]  = in_ready;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int bit_of(input int v, input int k);
    if (k < 0) return 0;
    return (v >> k) & 1;
  endfunction

  // Radix-4 digit d_i = Y[2i-1] + Y[2i] - 2*Y[2i+1], mapped to its action code.
  function automatic logic [2:0] exp_action(input int y, input int i);
    int d;
    d = bit_of(y, 2*i - 1) + bit_of(y, 2*i) - 2 * bit_of(y, 2*i + 1);
    case (d)
      1:       return 3'b100;
      2:       return 3'b010;
      -1:      return 3'b101;
      -2:      return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // ---------------- Monitor ----------------
  initial begin
    bit          seen;
    bit          hs_pend;
    logic [15:0] held;
    int          age;
    int          n_done;
    txn_t        t;
    logic [14:0] got_act;
    logic [14:0] exp_act;
    logic [4:0]  ir_bits;
    seen = 0; hs_pend = 0; held = '0; age = 0; n_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
        hs_pend = 0;
        out_ready = 1'b0;
        continue;
      end
      if (hs_pend) begin
        chk("hs_valid_drop", 32'(out_valid), 32'd0);
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_product_kept", 32'(product), 32'(held));
        seen = 0;
        hs_pend = 0;
        n_done++;
      end
      if (out_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid: got out_valid=1 with no pending operation (cycle %0d)", cyc);
          end else begin
            t = q.pop_front();
            chk("product", 32'(product), 32'(t.m) * 32'(t.y));
            chk("latency", 32'(cyc - t.c0), 32'd5);
            for (int i = 0; i < 5; i++) begin
              got_act[3*i +: 3] = act_log.exists(t.c0 + i) ? act_log[t.c0 + i] : 3'bxxx;
              exp_act[3*i +: 3] = exp_action(int'(t.y), i);
              ir_bits[i]        = ir_log.exists(t.c0 + i) ? ir_log[t.c0 + i] : 1'bx;
            end
            chk("actions", 32'(got_act), 32'(exp_act));
            chk("busy_in_ready", 32'({ir_bits, in_ready}), 32'd0);
          end
          seen = 1;
          held = product;
          age = 0;
        end else begin
          chk("bp_product_stable", 32'(product), 32'(held));
          chk("done_in_ready_low", 32'(in_ready), 32'd0);
          chk("done_action_zero", 32'(action), 32'd0);
          age++;
        end
        out_ready = (n_done == 1) ? (age >= 10) : ($urandom_range(0, 2) == 0);
        hs_pend = out_ready;
      end else begin
        out_ready = 1'($urandom);
        hs_pend = 0;
      end
    end
  end

  // ---------------- Driver ----------------
  task automatic send(input logic [7:0] m, input logic [7:0] y);
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (in_ready) begin
        ok = 1;
        break;
      end
      // Busy: random start pulses here must be ignored by the DUT.
      start        = 1'($urandom);
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles expected 1 (cycle %0d)", cyc);
      start = 1'b0;
      return;
    end
    start        = 1'b1;
    multiplicand = m;
    multiplier   = y;
    @(negedge clk);
    q.push_back('{m: m, y: y, c0: cyc});
    start = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (q.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0 (cycle %0d)", q.size(), cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rm, ry;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_action", 32'(action), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send(8'h00, 8'hB7);
    send(8'hFF, 8'hFF);
    send(8'h07, 8'h03);
    send(8'h80, 8'h80);
    for (int n = 0; n < 1500; n++) begin
      rm = 8'($urandom);
      ry = 8'($urandom);
      send(rm, ry);
    end
    send(8'hFF, 8'h00);
    send(8'h01, 8'hAA);
    drain();

    // Abort in the middle of CALC (cnt=2): nothing may come out for it.
    send(8'h5A, 8'hC3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_action", 32'(action), 32'd0);
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h12, 8'h34);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
